// File: rtl/bcd_convert_scheduler_if.sv
// Request/result bundle between requesters, the shared BCD engine and its result consumer.
// The master side drives requests and result acceptance; the slave side is the scheduler.
interface bcd_convert_scheduler_if #(
  parameter int NREQ  = 4,
  parameter int NBITS = 8,
  parameter int NDECS = 3
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]       req_valid;
  logic [NREQ*NBITS-1:0] req_binary;
  logic [NREQ-1:0]       req_ready;
  logic                  res_valid;
  logic                  res_ready;
  logic [NDECS*4-1:0]    res_decimal;
  logic [IDW-1:0]        res_id;
  logic                  res_overflow;

  modport master (
    output req_valid, req_binary, res_ready,
    input  req_ready, res_valid, res_decimal, res_id, res_overflow
  );

  modport slave (
    input  req_valid, req_binary, res_ready,
    output req_ready, res_valid, res_decimal, res_id, res_overflow
  );
endinterface

// File: rtl/bcd_convert_scheduler.sv
// Round-robin scheduler sharing one iterative shift-add-3 binary-to-BCD engine
// between NREQ requesters; results return tagged with the owning requester id.
module bcd_convert_scheduler #(
  parameter int NREQ  = 4,
  parameter int NBITS = 8,
  parameter int NDECS = 3
) (
  input  logic                    clock,
  input  logic                    reset,
  bcd_convert_scheduler_if.slave  bus,
  output logic                    busy
);
  localparam int IDW = $clog2(NREQ);
  localparam int DW  = NDECS * 4;
  localparam int SW  = DW + NBITS;
  localparam int CW  = $clog2(NBITS + 1);

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t           state_q;
  logic [IDW-1:0]   rr_ptr_q;
  logic [IDW-1:0]   id_q;
  logic [CW-1:0]    cnt_q;
  logic             ovf_q;
  logic [SW-1:0]    sh_q;
  logic             res_valid_q;
  logic [DW-1:0]    res_decimal_q;
  logic [IDW-1:0]   res_id_q;
  logic             res_ovf_q;
  logic             busy_q;

  logic [NREQ-1:0]  grant_d;
  logic [IDW-1:0]   gid_d;
  logic             found_d;
  logic [NBITS-1:0] bin_sel_d;
  logic [SW-1:0]    adj_d;
  logic [SW-1:0]    sh_d;
  logic             ovf_d;
  int               idx;

  function automatic logic [SW-1:0] add3_digits(input logic [SW-1:0] s);
    logic [SW-1:0] r;
    r = s;
    for (int d = 0; d < NDECS; d++) begin
      if (r[NBITS+4*d +: 4] >= 4'd5)
        r[NBITS+4*d +: 4] = r[NBITS+4*d +: 4] + 4'd3;
    end
    return r;
  endfunction

  // Round-robin search starting at rr_ptr, wrapping NREQ-1 -> 0
  always_comb begin
    grant_d = '0;
    gid_d   = '0;
    found_d = 1'b0;
    idx     = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(rr_ptr_q) + k) % NREQ;
      if (!found_d && bus.req_valid[idx]) begin
        grant_d[idx] = 1'b1;
        gid_d        = IDW'(idx);
        found_d      = 1'b1;
      end
    end
  end

  assign bin_sel_d = bus.req_binary[gid_d*NBITS +: NBITS];
  assign adj_d     = add3_digits(sh_q);
  assign sh_d      = {adj_d[SW-2:0], 1'b0};
  assign ovf_d     = ovf_q | adj_d[SW-1];

  assign bus.req_ready    = (state_q == IDLE && !reset) ? grant_d : '0;
  assign bus.res_valid    = res_valid_q;
  assign bus.res_decimal  = res_decimal_q;
  assign bus.res_id       = res_id_q;
  assign bus.res_overflow = res_ovf_q;
  assign busy             = busy_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      rr_ptr_q      <= '0;
      id_q          <= '0;
      cnt_q         <= '0;
      ovf_q         <= 1'b0;
      res_valid_q   <= 1'b0;
      res_decimal_q <= '0;
      res_id_q      <= '0;
      res_ovf_q     <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (found_d) begin
            sh_q    <= {{DW{1'b0}}, bin_sel_d};
            id_q    <= gid_d;
            ovf_q   <= 1'b0;
            cnt_q   <= CW'(NBITS);
            busy_q  <= 1'b1;
            state_q <= CONV;
          end
        end
        CONV: begin
          sh_q  <= sh_d;
          ovf_q <= ovf_d;
          cnt_q <= cnt_q - CW'(1);
          // Last iteration publishes the result straight from the next-state digits
          if (cnt_q == CW'(1)) begin
            state_q       <= DONE;
            res_valid_q   <= 1'b1;
            res_decimal_q <= sh_d[SW-1 -: DW];
            res_id_q      <= id_q;
            res_ovf_q     <= ovf_d;
          end
        end
        DONE: begin
          if (bus.res_ready) begin
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            rr_ptr_q    <= IDW'((int'(id_q) + 1) % NREQ);
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bcd_convert_scheduler.sv
// Directed and randomized checks of the BCD conversion scheduler against an arithmetic
// reference model; a second instance with NDECS=2 covers the overflow path.
module tb_bcd_convert_scheduler;
  logic clk = 1'b0;
  logic rst;
  logic busy1, busy2;
  int   ntests = 0;
  int   nfail  = 0;
  int   ptr_m  = 0;

  always #5 clk = ~clk;

  bcd_convert_scheduler_if #(.NREQ(4), .NBITS(8), .NDECS(3)) bus1 ();
  bcd_convert_scheduler_if #(.NREQ(4), .NBITS(8), .NDECS(2)) bus2 ();

  bcd_convert_scheduler #(.NREQ(4), .NBITS(8), .NDECS(3)) dut1 (
    .clock (clk),
    .reset (rst),
    .bus   (bus1.slave),
    .busy  (busy1)
  );

  bcd_convert_scheduler #(.NREQ(4), .NBITS(8), .NDECS(2)) dut2 (
    .clock (clk),
    .reset (rst),
    .bus   (bus2.slave),
    .busy  (busy2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] bcd_ref(input int v, input int nd);
    logic [11:0] r;
    int m;
    r = '0;
    m = v;
    for (int d = 0; d < nd; d++) begin
      r[4*d +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return r;
  endfunction

  function automatic int pow10(input int nd);
    int p;
    p = 1;
    for (int d = 0; d < nd; d++) p = p * 10;
    return p;
  endfunction

  function automatic int rr_pick(input logic [3:0] mask, input int ptr);
    for (int k = 0; k < 4; k++) begin
      if (mask[(ptr + k) % 4]) return (ptr + k) % 4;
    end
    return 0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction on the NDECS=3 instance: offer, accept, convert, hold, handshake
  task automatic do_req(input logic [3:0] mask, input logic [31:0] bin, input int hold, input string tag);
    int g, n, v;
    logic [3:0] m;
    logic [11:0] ed;
    logic eo;
    m = mask;
    bus1.req_valid  = m;
    bus1.req_binary = bin;
    #1;
    g  = rr_pick(m, ptr_m);
    v  = int'(bin[g*8 +: 8]);
    ed = bcd_ref(v, 3);
    eo = (v >= pow10(3));
    chk({tag, "_grant"}, 32'(bus1.req_ready), 32'(1 << g));
    tick();
    m[g] = 1'b0;
    bus1.req_valid  = m;
    bus1.req_binary = $urandom;
    #1;
    chk({tag, "_busy"}, 32'(busy1), 32'd1);
    chk({tag, "_rdy_conv"}, 32'(bus1.req_ready), 32'd0);
    n = 1;
    while (!bus1.res_valid && n < 40) begin
      tick();
      n++;
    end
    chk({tag, "_latency"}, n, 32'd9);
    chk({tag, "_dec"}, 32'(bus1.res_decimal), 32'(ed));
    chk({tag, "_id"}, 32'(bus1.res_id), 32'(g));
    chk({tag, "_ovf"}, 32'(bus1.res_overflow), 32'(eo));
    for (int i = 0; i < hold; i++) begin
      tick();
      chk({tag, "_hold_vld"}, 32'(bus1.res_valid), 32'd1);
      chk({tag, "_hold_dec"}, 32'(bus1.res_decimal), 32'(ed));
      chk({tag, "_hold_id"}, 32'(bus1.res_id), 32'(g));
      chk({tag, "_hold_rdy"}, 32'(bus1.req_ready), 32'd0);
    end
    bus1.res_ready = 1'b1;
    tick();
    bus1.res_ready = 1'b0;
    bus1.req_valid = 4'b0000;
    #1;
    chk({tag, "_vld_off"}, 32'(bus1.res_valid), 32'd0);
    chk({tag, "_busy_off"}, 32'(busy1), 32'd0);
    chk({tag, "_dec_keep"}, 32'(bus1.res_decimal), 32'(ed));
    ptr_m = (g + 1) % 4;
  endtask

  task automatic do_req2(input int v, input string tag);
    int n;
    bus2.req_valid  = 4'b0001;
    bus2.req_binary = {24'(0), 8'(v)};
    #1;
    chk({tag, "_grant"}, 32'(bus2.req_ready), 32'd1);
    tick();
    bus2.req_valid = 4'b0000;
    n = 1;
    while (!bus2.res_valid && n < 40) begin
      tick();
      n++;
    end
    chk({tag, "_latency"}, n, 32'd9);
    chk({tag, "_dec"}, 32'(bus2.res_decimal), 32'(bcd_ref(v, 2) & 12'h0FF));
    chk({tag, "_ovf"}, 32'(bus2.res_overflow), 32'(v >= pow10(2)));
    bus2.res_ready = 1'b1;
    tick();
    bus2.res_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  rmask;
    logic [31:0] rbin;
    rst = 1'b1;
    bus1.req_valid = 4'b1111; bus1.req_binary = 32'h04030201; bus1.res_ready = 1'b0;
    bus2.req_valid = 4'b0000; bus2.req_binary = '0;           bus2.res_ready = 1'b0;
    tick();
    tick();
    chk("rst_ready", 32'(bus1.req_ready), 32'd0);
    chk("rst_vld", 32'(bus1.res_valid), 32'd0);
    chk("rst_dec", 32'(bus1.res_decimal), 32'd0);
    chk("rst_id", 32'(bus1.res_id), 32'd0);
    chk("rst_ovf", 32'(bus1.res_overflow), 32'd0);
    chk("rst_busy", 32'(busy1), 32'd0);
    rst = 1'b0;
    bus1.req_valid = 4'b0000;
    tick();

    // All four requesters held valid: served in id order, then pointer wraps to 0
    do_req(4'b1111, 32'h04030201, 0, "rr0");
    do_req(4'b1110, 32'h04030201, 0, "rr1");
    do_req(4'b1100, 32'h04030201, 0, "rr2");
    do_req(4'b1000, 32'h04030201, 0, "rr3");
    do_req(4'b1001, 32'h99000007, 0, "rr_wrap");

    do_req(4'b0001, 32'h000000FF, 0, "v255");
    do_req(4'b0001, 32'h00000000, 0, "v0");
    do_req(4'b0001, 32'h00000009, 0, "v9");
    do_req(4'b0001, 32'h0000000A, 0, "v10");
    do_req(4'b0001, 32'h00000063, 0, "v99");
    do_req(4'b0001, 32'h00000064, 0, "v100");

    do_req(4'b0110, 32'h00B40000, 6, "hold");
    do_req(4'b0100, 32'h00420000, 0, "pre_rst");

    // Reset in the 4th conversion cycle of a job from requester 1
    bus1.req_valid  = 4'b0010;
    bus1.req_binary = 32'h00004D00;
    tick();
    bus1.req_valid = 4'b0000;
    tick();
    tick();
    tick();
    rst = 1'b1;
    bus1.req_valid  = 4'b1100;
    bus1.req_binary = 32'h307B0000;
    #1;
    chk("mid_rst_ready", 32'(bus1.req_ready), 32'd0);
    tick();
    chk("mid_rst_busy", 32'(busy1), 32'd0);
    chk("mid_rst_vld", 32'(bus1.res_valid), 32'd0);
    chk("mid_rst_dec", 32'(bus1.res_decimal), 32'd0);
    rst = 1'b0;
    ptr_m = 0;
    do_req(4'b1100, 32'h307B0000, 0, "post_rst");

    for (int t = 0; t < 20; t++) begin
      rmask = 4'($urandom_range(1, 15));
      rbin  = $urandom;
      do_req(rmask, rbin, $urandom_range(0, 3), "rand");
    end

    do_req2(200, "d2_200");
    do_req2(99, "d2_99");
    for (int t = 0; t < 6; t++) do_req2($urandom_range(0, 255), "d2_rand");

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
